// File: rtl/serial_wide_compare_pkg.sv
// Shared definitions for the serial wide magnitude comparator:
// one-hot result codes and the control FSM state encoding.
package serial_wide_compare_pkg;

  // One-hot comparison results; also used as the cascade code between nibbles.
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_wide_compare_nibble_cmp_cell.sv
// 4-bit cascade comparator cell. A nibble difference decides the result
// outright; equal nibbles pass the less-significant verdict through.
module nibble_cmp_cell
  import serial_wide_compare_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] cascade_in,
  output logic [2:0] result
);

  // Pick this nibble's verdict, deferring to the cascade when equal.
  always_comb begin
    // NOTE: assign a default before any branching so no latch is inferred.
    result = cascade_in;
    if (a > b)      result = CMP_GT;
    else if (a < b) result = CMP_LT;
  end

endmodule

// File: rtl/serial_wide_compare.sv
// Sequential magnitude comparator for wide unsigned operands. Operands are
// captured on iStart and walked LSB nibble first through a single cascade
// cell; the last (most significant) nibble's verdict is the final result.
module serial_wide_compare
  import serial_wide_compare_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [4*NIBBLES-1:0] iData_a,
  input  logic [4*NIBBLES-1:0] iData_b,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2:0]           oData
);

  localparam int              WIDTH    = 4 * NIBBLES;
  localparam int              CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [CNT_W-1:0] nibCnt;
  logic [2:0]       cascade;
  logic [3:0]       nibA;
  logic [3:0]       nibB;
  logic [2:0]       cellOut;
  logic             loadOps;
  logic             stepRun;
  logic             lastNib;

  // Nibble select: shift the current nibble down to bit 0.
  assign nibA    = 4'(aReg >> {nibCnt, 2'b00});
  assign nibB    = 4'(bReg >> {nibCnt, 2'b00});
  assign lastNib = (nibCnt == LAST_NIB);

  nibble_cmp_cell uCell (
    .a          (nibA),
    .b          (nibB),
    .cascade_in (cascade),
    .result     (cellOut)
  );

  // Next-state and control decode; outputs follow the current state only.
  always_comb begin
    stateNext = state;
    loadOps   = 1'b0;
    stepRun   = 1'b0;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          loadOps   = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        oBusy   = 1'b1;
        stepRun = 1'b1;
        if (lastNib) stateNext = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, operand, counter, cascade and result registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      // NOTE: operand registers are reset too, so no X ever reaches the cell.
      aReg    <= '0;
      bReg    <= '0;
      nibCnt  <= '0;
      cascade <= CMP_EQ;
      oData   <= CMP_EQ;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      state <= stateNext;
      if (loadOps) begin
        aReg    <= iData_a;
        bReg    <= iData_b;
        nibCnt  <= '0;
        cascade <= CMP_EQ;
      end
      if (stepRun) begin
        cascade <= cellOut;
        if (lastNib) begin
          nibCnt <= '0;
          oData  <= cellOut;
        end else begin
          nibCnt <= nibCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_wide_compare.sv
// Scoreboard bench: drivers push the expected result and completion edge,
// monitors pop and compare whenever a DUT raises oDone.
module tb_serial_wide_compare;
  import serial_wide_compare_pkg::*;

  typedef struct {
    logic [2:0]  res;
    int unsigned dueEdge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  // NIBBLES=4 instance
  logic        start4 = 1'b0;
  logic [15:0] a4 = '0;
  logic [15:0] b4 = '0;
  logic        busy4;
  logic        done4;
  logic [2:0]  data4;
  exp_t        q4[$];

  // NIBBLES=1 instance
  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        busy1;
  logic        done1;
  logic [2:0]  data1;
  exp_t        q1[$];

  serial_wide_compare #(.NIBBLES(4)) dut4 (
    .iClk(clk), .iRst(rst), .iStart(start4), .iData_a(a4), .iData_b(b4),
    .oBusy(busy4), .oDone(done4), .oData(data4)
  );

  serial_wide_compare #(.NIBBLES(1)) dut1 (
    .iClk(clk), .iRst(rst), .iStart(start1), .iData_a(a1), .iData_b(b1),
    .oBusy(busy1), .oDone(done1), .oData(data1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-nibble instance.
  always @(negedge clk) begin
    if (busy4 && done4) check("busy4_done4_overlap", 1, 0);
    if (done4) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("data4", data4, e.res);
        check("done4_edge", cyc, e.dueEdge);
      end
    end
  end

  // Monitor for the 1-nibble instance.
  always @(negedge clk) begin
    if (busy1 && done1) check("busy1_done1_overlap", 1, 0);
    if (done1) begin
      if (q1.size() == 0) begin
        check("done1_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("data1", data1, e.res);
        check("done1_edge", cyc, e.dueEdge);
      end
    end
  end

  // Start one comparison on the 4-nibble DUT, then scramble the inputs.
  task automatic start4Cmp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] res);
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{res: res, dueEdge: cyc + 4});
    start4 = 1'b0;
    a4 = ~a; b4 = ~b;
  endtask

  task automatic start1Cmp(input logic [3:0] a, input logic [3:0] b, input logic [2:0] res);
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    q1.push_back('{res: res, dueEdge: cyc + 1});
    start1 = 1'b0;
    a1 = ~a; b1 = ~b;
  endtask

  // Wait for both scoreboards to empty, plus settle time back to IDLE.
  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0 || q1.size() != 0) begin
      check("drain_timeout", 1, 0);
      q4.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_data4", data4, CMP_EQ);
    check("rst_data1", data1, CMP_EQ);
    @(negedge clk);
    rst = 1'b0;

    // Equal operands: busy for exactly 4 sampled cycles, result held at 001.
    start4Cmp(16'h1234, 16'h1234, CMP_EQ);
    for (int i = 0; i < 4; i++) begin
      check("eq_busy", busy4, 1);
      check("eq_data_held", data4, CMP_EQ);
      @(posedge clk); #1;
    end
    check("eq_busy_after", busy4, 0);
    drain();

    // Upper nibble dominates.
    start4Cmp(16'h8000, 16'h7FFF, CMP_GT);
    drain();

    // Mid-nibble difference; oData must keep the previous result while running.
    start4Cmp(16'h00F0, 16'h0100, CMP_LT);
    check("mid_data_held", data4, CMP_GT);
    drain();

    // Only the LSB nibble differs.
    start4Cmp(16'hABCD, 16'hABCC, CMP_GT);
    drain();

    // Start held high for 10 edges: accepted at s and s+6 only.
    @(negedge clk);
    a4 = 16'h0001; b4 = 16'h0002; start4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{res: CMP_LT, dueEdge: cyc + 4});
    q4.push_back('{res: CMP_LT, dueEdge: cyc + 10});
    repeat (9) @(posedge clk);
    #1 start4 = 1'b0;
    drain();

    // Reset during the second RUN cycle: no done, result back to 001.
    @(negedge clk);
    a4 = 16'h0F00; b4 = 16'h0010; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy_before", busy4, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy4, 0);
    check("midrst_done", done4, 0);
    check("midrst_data", data4, CMP_EQ);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    start4Cmp(16'hFFFF, 16'h0000, CMP_GT);
    drain();

    // Single-nibble build.
    start1Cmp(4'h3, 4'h9, CMP_LT);
    check("n1_busy", busy1, 1);
    @(posedge clk); #1;
    check("n1_busy_after", busy1, 0);
    drain();
    start1Cmp(4'h9, 4'h3, CMP_GT);
    drain();
    start1Cmp(4'h5, 4'h5, CMP_EQ);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
